// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out 8 data bits + odd parity + stop, check device ACK.
// Latency: INHIBIT_CYCLES of clock inhibit, then one frame paced by the device clock; done/err one cycle after ACK/timeout.
// Backpressure: tx_start is accepted only while idle (busy=0); requests during busy are dropped, not queued.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_TIMEOUT  = 375000,
  parameter int BIT_TIMEOUT    = 5000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [18:0] INH_LAST  = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] INH_PRE   = 19'(INHIBIT_CYCLES - 2);
  localparam logic [18:0] START_LIM = 19'(START_TIMEOUT);
  localparam logic [18:0] BIT_LIM   = 19'(BIT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RELEASE, TX, ACK, WAIT_IDLE, ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [18:0]    timer_q, timer_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     frame_q, frame_d;
  logic           clk_oe_q, clk_oe_d;
  logic           data_oe_q, data_oe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, fall_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           fall_act;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: a new clock level is taken only after FILTER_LEN equal samples; fall_q strobes on 1->0.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_LAST) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
        fall_q     <= ~clk_s2_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Our own inhibit also produces a filtered fall; only device edges in the frame states count.
  assign fall_act = fall_q && (state_q == RELEASE || state_q == TX || state_q == ACK);

  // Next-state and next-output logic; the timer runs per state and restarts on every device fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timer_d   = timer_q;

    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_start) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = 4'd0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (timer_q == INH_PRE) data_oe_d = 1'b1;
        if (timer_q >= INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (fall_q) begin
          data_oe_d = ~frame_q[0];
          bit_cnt_d = 4'd1;
          state_d   = TX;
        end else if (timer_q > START_LIM) begin
          state_d = ERROR;
        end
      end
      TX: begin
        if (fall_q) begin
          // Index 9 is the stop bit (1), so this releases data on the 10th fall.
          data_oe_d = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ACK;
        end else if (timer_q > BIT_LIM) begin
          state_d = ERROR;
        end
      end
      ACK: begin
        data_oe_d = 1'b0;
        if (fall_q) begin
          state_d = dat_s2_q ? ERROR : WAIT_IDLE;
        end else if (timer_q > BIT_LIM) begin
          state_d = ERROR;
        end
      end
      WAIT_IDLE: begin
        if (filt_q && dat_s2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_q > BIT_LIM) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entering ERROR drops both lines and busy in the same cycle err pulses.
    if (state_d == ERROR && state_q != ERROR) begin
      err_d     = 1'b1;
      busy_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end

    if (state_d != state_q || fall_act) timer_d = '0;
    else if (timer_q != '1)             timer_d = timer_q + 19'd1;
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device clocks frames out of the host and compares against a frame model.
// Latency: device half period of HALF system cycles; timeouts scaled down through parameters.
// Backpressure: new commands only issued after busy drops; intrusive tx_start pulses probe the ignore-while-busy rule.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int STO  = 400;
  localparam int BTO  = 150;
  localparam int HALF = 40;

  logic       clk_25mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_runs = 0, run_cur = 0, last_run = 0;
  logic last_run_dat = 1'b0, prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

  // Open-collector bus: anyone pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low) & ~glitch;
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .BIT_TIMEOUT(BTO), .FILTER_LEN(4)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // Pulse counters and inhibit-run measurement, sampled mid-cycle.
  always @(negedge clk_25mhz) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (ps2_clk_oe) begin
      run_cur++;
    end else if (prev_clk_oe) begin
      last_run     = run_cur;
      last_run_dat = prev_data_oe;
      inh_runs++;
      run_cur = 0;
    end
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device sees it on rising edges: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = (ones % 2 == 0);
    return {1'b1, par, d};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk_25mhz);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk_25mhz);
    tx_start = 1'b0;
  endtask

  // Device side: wait for inhibit and release, then clock nfalls edges, sampling data before each rise.
  task automatic dev_frame(input int nfalls, input bit ack, input bit glitch_en,
                           output logic [9:0] bits, output logic sb);
    int n;
    bits = '1;
    sb   = 1'b1;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin @(negedge clk_25mhz); n++; end
    check("inhibit_seen", 32'(ps2_clk_oe), 32'd1);
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin @(negedge clk_25mhz); n++; end
    check("release_seen", 32'(ps2_clk_oe), 32'd0);
    repeat (20) @(negedge clk_25mhz);
    sb = ps2_data_in;
    for (int i = 0; i < nfalls; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_25mhz);
      if (i < 10) bits[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (i == 9 && ack) dev_data_low = 1'b1;
      repeat (HALF / 2) @(negedge clk_25mhz);
      if (glitch_en) begin
        #5 glitch = 1'b1;
        #1 glitch = 1'b0;
      end
      repeat (HALF / 2) @(negedge clk_25mhz);
      if (i == 10) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin @(negedge clk_25mhz); n++; end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic do_txn(input logic [7:0] d, input bit glitch_en, input bit intrude);
    logic [9:0] bits;
    logic sb;
    int d0, e0, r0;
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    start_tx(d);
    fork
      dev_frame(11, 1'b1, glitch_en, bits, sb);
      if (intrude) begin
        repeat (300) @(negedge clk_25mhz);
        tx_data  = ~d;
        tx_start = 1'b1;
        @(negedge clk_25mhz);
        tx_start = 1'b0;
      end
    join
    wait_idle(BTO + 100);
    repeat (30) @(negedge clk_25mhz);
    check("start_bit", 32'(sb), 32'd0);
    check("frame", 32'(bits), 32'(exp_frame(d)));
    check("inhibit_len", 32'(last_run), 32'(INH));
    check("inhibit_last_data", 32'(last_run_dat), 32'd1);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("err_pulses", 32'(err_cnt - e0), 32'd0);
    check("inhibit_runs", 32'(inh_runs - r0), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic sb;
    int n, d0, e0;
    logic [7:0] rd;

    // Reset state.
    repeat (5) @(negedge clk_25mhz);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_25mhz);

    // Directed frames, including explicit parity extremes.
    do_txn(8'hF4, 1'b0, 1'b0);
    do_txn(8'h00, 1'b0, 1'b0);
    check("parity_00", 32'(exp_frame(8'h00) >> 8) & 32'd1, 32'd1);
    do_txn(8'hFF, 1'b0, 1'b0);
    do_txn(8'h5A, 1'b1, 1'b1);

    // Randomized frames with random glitches and intrusive requests.
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      do_txn(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // NACK: device leaves data high at the 11th fall.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h3C);
    dev_frame(11, 1'b0, 1'b0, bits, sb);
    wait_idle(BTO + 100);
    check("nack_frame", 32'(bits), 32'(exp_frame(8'h3C)));
    check("nack_err", 32'(err_cnt - e0), 32'd1);
    check("nack_done", 32'(done_cnt - d0), 32'd0);

    // No device clock after release.
    start_tx(8'hF4);
    dev_frame(0, 1'b0, 1'b0, bits, sb);
    n = 20;
    while (!err && n < STO + 100) begin @(negedge clk_25mhz); n++; end
    check("start_to_err", 32'(err), 32'd1);
    check("start_to_window", 32'(n >= STO && n <= STO + 4), 32'd1);
    check("start_to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("start_to_data_oe", 32'(ps2_data_oe), 32'd0);
    check("start_to_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk_25mhz);

    // Device stops clocking after the 5th fall.
    d0 = done_cnt;
    start_tx(8'hA5);
    dev_frame(5, 1'b0, 1'b0, bits, sb);
    n = 0;
    while (!err && n < BTO + 200) begin @(negedge clk_25mhz); n++; end
    check("bit_to_err", 32'(err), 32'd1);
    check("bit_to_window", 32'(n >= BTO - 80 && n <= BTO - 55), 32'd1);
    check("bit_to_busy", 32'(busy), 32'd0);
    check("bit_to_done", 32'(done_cnt - d0), 32'd0);
    repeat (5) @(negedge clk_25mhz);

    // Asynchronous reset mid-frame releases lines without waiting for a clock edge.
    start_tx(8'h00);
    dev_frame(4, 1'b0, 1'b0, bits, sb);
    check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    #7 rst_n = 1'b0;
    #1;
    check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk_25mhz);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_25mhz);
    do_txn(8'hC3, 1'b0, 1'b0);

    check("done_err_overlap", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
